// File: rtl/uram_row_arbiter_pkg.sv
// Shared state encoding, default URAM widths and pointer helper for the row URAM arbiter.
// Pure declarations: no latency, no backpressure.
package uram_row_arbiter_pkg;

    localparam int URAM_ADDR_W = 12;
    localparam int URAM_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANTED = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uram_row_arbiter_rr_picker.sv
// Combinational round-robin first-one search starting at ptr_i; zero latency.
// No backpressure: vld_o simply drops when no request is present.
module rr_picker #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    always_comb begin : p_pick
        int k;
        k     = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!vld_o && req_i[IDX_W'(k)]) begin
                vld_o              = 1'b1;
                idx_o              = IDX_W'(k);
                gnt_o[IDX_W'(k)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uram_row_arbiter.sv
// Round-robin owner of a row's shared URAM port; grant and URAM outputs registered, 1-cycle latency.
// No backpressure: losers wait on req. Optional grant timeout under ARB_GRANT_TIMEOUT_EN.
module uram_row_arbiter
    import uram_row_arbiter_pkg::*;
#(
    parameter int NUM_CORES     = 4,
    parameter int ADDR_W        = URAM_ADDR_W,
    parameter int DATA_W        = URAM_DATA_W,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CORES-1:0]                i_core_req,
    input  logic [NUM_CORES-1:0]                i_core_locked,
    output logic [NUM_CORES-1:0]                o_core_grant,
    input  logic [NUM_CORES-1:0]                i_core_uram_en,
    input  logic [NUM_CORES-1:0]                i_core_uram_wr_en,
    input  logic [NUM_CORES-1:0][ADDR_W-1:0]    i_core_uram_addr,
    input  logic [NUM_CORES-1:0][DATA_W-1:0]    i_core_uram_wr_data,
    output logic                                o_URAM_en,
    output logic                                o_URAM_wr_en,
    output logic [ADDR_W-1:0]                   o_URAM_addr,
    output logic [DATA_W-1:0]                   o_URAM_wr_data,
    input  logic                                i_uram_emptied,
    output logic [NUM_CORES-1:0]                o_core_uram_emptied,
    output logic [$clog2(NUM_CORES)-1:0]        o_owner,
    output logic                                o_grant_timeout
);

    localparam int IDX_W = $clog2(NUM_CORES);

    arb_state_e             state_q;
    logic [NUM_CORES-1:0]   grant_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       rr_q;
    logic [IDX_W-1:0]       rr_d;
    logic                   seen_locked_q;
    logic                   uram_en_q;
    logic                   uram_wr_en_q;
    logic [ADDR_W-1:0]      uram_addr_q;
    logic [DATA_W-1:0]      uram_wr_data_q;
    logic                   emptied_q;

    logic [NUM_CORES-1:0]   pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;
    logic                   owner_req;
    logic                   owner_locked;

`ifdef ARB_GRANT_TIMEOUT_EN
    localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);
    logic [CNT_W-1:0]       cnt_q;
    logic                   timeout_q;
    assign o_grant_timeout = timeout_q;
`else
    // Timeout disabled: the parameter stays on the interface so both builds share one port map.
    logic unused_grant_timeout;
    assign unused_grant_timeout = (GRANT_TIMEOUT > 0);
    assign o_grant_timeout      = 1'b0;
`endif

    rr_picker #(.N(NUM_CORES)) u_picker (
        .req_i (i_core_req),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    assign owner_req    = i_core_req[owner_q];
    assign owner_locked = i_core_locked[owner_q];
    assign rr_d         = IDX_W'(rr_next(int'(owner_q), NUM_CORES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ARB_IDLE;
            grant_q        <= '0;
            owner_q        <= '0;
            rr_q           <= '0;
            seen_locked_q  <= 1'b0;
            uram_en_q      <= 1'b0;
            uram_wr_en_q   <= 1'b0;
            uram_addr_q    <= '0;
            uram_wr_data_q <= '0;
            emptied_q      <= 1'b0;
`ifdef ARB_GRANT_TIMEOUT_EN
            cnt_q          <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            emptied_q <= i_uram_emptied;
`ifdef ARB_GRANT_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            // Only the owner drives the port, and only while its tenure is live.
            if (state_q == ARB_GRANTED) begin
                uram_en_q      <= i_core_uram_en[owner_q];
                uram_wr_en_q   <= i_core_uram_wr_en[owner_q];
                uram_addr_q    <= i_core_uram_addr[owner_q];
                uram_wr_data_q <= i_core_uram_wr_data[owner_q];
            end else begin
                uram_en_q      <= 1'b0;
                uram_wr_en_q   <= 1'b0;
            end

            case (state_q)
                ARB_GRANTED: begin
                    if (owner_locked) begin
                        seen_locked_q <= 1'b1;
                    end else if (seen_locked_q || !owner_req) begin
                        state_q <= ARB_RELEASE;
                        grant_q <= '0;
                        rr_q    <= rr_d;
`ifdef ARB_GRANT_TIMEOUT_EN
                    end else if (cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
                        state_q   <= ARB_RELEASE;
                        grant_q   <= '0;
                        rr_q      <= rr_d;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                // IDLE and RELEASE both arbitrate, so back-to-back tenures see a single idle cycle.
                default: begin
                    if (pick_vld) begin
                        state_q       <= ARB_GRANTED;
                        grant_q       <= pick_gnt;
                        owner_q       <= pick_idx;
                        seen_locked_q <= 1'b0;
`ifdef ARB_GRANT_TIMEOUT_EN
                        cnt_q         <= '0;
`endif
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_core_grant        = grant_q;
    assign o_owner             = owner_q;
    assign o_URAM_en           = uram_en_q;
    assign o_URAM_wr_en        = uram_wr_en_q;
    assign o_URAM_addr         = uram_addr_q;
    assign o_URAM_wr_data      = uram_wr_data_q;
    assign o_core_uram_emptied = {NUM_CORES{emptied_q}};

endmodule

// File: tb/tb_uram_row_arbiter.sv
// Directed bench for uram_row_arbiter: tenure handover, datapath muxing, reset and grant-timeout cases.
module tb_uram_row_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic [N-1:0]           req;
    logic [N-1:0]           locked;
    logic [N-1:0]           en;
    logic [N-1:0]           wr_en;
    logic [N-1:0][AW-1:0]   addr;
    logic [N-1:0][DW-1:0]   wdata;
    logic                   emptied_in;

    logic [N-1:0]           grant;
    logic                   u_en;
    logic                   u_wr;
    logic [AW-1:0]          u_addr;
    logic [DW-1:0]          u_data;
    logic [N-1:0]           emptied;
    logic [1:0]             owner;
    logic                   tmo;

    int n_cmp = 0;
    int n_bad = 0;
    int order [3] = '{0, 2, 3};
    logic [1:0] c;

    uram_row_arbiter #(
        .NUM_CORES     (N),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .GRANT_TIMEOUT (8)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_core_req          (req),
        .i_core_locked       (locked),
        .o_core_grant        (grant),
        .i_core_uram_en      (en),
        .i_core_uram_wr_en   (wr_en),
        .i_core_uram_addr    (addr),
        .i_core_uram_wr_data (wdata),
        .o_URAM_en           (u_en),
        .o_URAM_wr_en        (u_wr),
        .o_URAM_addr         (u_addr),
        .o_URAM_wr_data      (u_data),
        .i_uram_emptied      (emptied_in),
        .o_core_uram_emptied (emptied),
        .o_owner             (owner),
        .o_grant_timeout     (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, and check grant is never multi-hot.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot", 32'($onehot0(grant)), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        req        = '0;
        locked     = '0;
        en         = '0;
        wr_en      = '0;
        addr       = '0;
        wdata      = '0;
        emptied_in = 1'b0;

        // T1: reset held 200ns, then idle with no requests
        repeat (20) begin
            tick();
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_en", 32'(u_en), 32'd0);
            chk("rst_owner", 32'(owner), 32'd0);
        end
        chk("rst_addr", 32'(u_addr), 32'd0);
        chk("rst_empt", 32'(emptied), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        reset = 1'b0;
        repeat (5) begin
            tick();
            chk("idle_grant", 32'(grant), 32'd0);
            chk("idle_en", 32'(u_en), 32'd0);
            chk("idle_owner", 32'(owner), 32'd0);
        end

        emptied_in = 1'b1;
        tick();
        chk("empt_hi", 32'(emptied), 32'hF);
        emptied_in = 1'b0;
        tick();
        chk("empt_lo", 32'(emptied), 32'h0);

        // T2: core1 single tenure, 10 locked cycles
        req[1] = 1'b1;
        tick();
        chk("t2_grant", 32'(grant), 32'h2);
        chk("t2_owner", 32'(owner), 32'd1);
        locked[1] = 1'b1;
        en[1]     = 1'b1;
        wr_en[1]  = 1'b1;
        addr[1]   = 12'h010;
        wdata[1]  = 32'd5;
        repeat (10) begin
            tick();
            chk("t2_hold", 32'(grant), 32'h2);
            chk("t2_en", 32'(u_en), 32'd1);
            chk("t2_wr", 32'(u_wr), 32'd1);
            chk("t2_addr", 32'(u_addr), 32'h010);
            chk("t2_data", u_data, 32'd5);
        end
        locked[1] = 1'b0;
        req[1]    = 1'b0;
        en[1]     = 1'b0;
        wr_en[1]  = 1'b0;
        tick();
        chk("t2_drop", 32'(grant), 32'd0);
        chk("t2_en_off", 32'(u_en), 32'd0);
        chk("t2_addr_hold", 32'(u_addr), 32'h010);
        tick();
        chk("t2_idle", 32'(grant), 32'd0);
        chk("t2_last_owner", 32'(owner), 32'd1);

        // Short reset so the pointer is back at core 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_rst_owner", 32'(owner), 32'd0);

        // T3: cores 0,2,3 together, 4-cycle tenures, one idle cycle between
        req = 4'b1101;
        tick();
        for (int k = 0; k < 3; k++) begin
            c = 2'(order[k]);
            chk("t3_grant", 32'(grant), 32'd1 << c);
            chk("t3_owner", 32'(owner), 32'(c));
            locked[c] = 1'b1;
            repeat (4) begin
                tick();
                chk("t3_hold", 32'(grant), 32'd1 << c);
            end
            locked[c] = 1'b0;
            req[c]    = 1'b0;
            tick();
            chk("t3_gap", 32'(grant), 32'd0);
            tick();
        end
        chk("t3_done", 32'(grant), 32'd0);

        // T4: core2 writes (and raises locked) while core0 owns
        req[0] = 1'b1;
        tick();
        chk("t4_grant", 32'(grant), 32'h1);
        locked[0] = 1'b1;
        en[0]     = 1'b1;
        wr_en[0]  = 1'b1;
        addr[0]   = 12'h100;
        wdata[0]  = 32'hAAAA;
        locked[2] = 1'b1;
        en[2]     = 1'b1;
        wr_en[2]  = 1'b1;
        addr[2]   = 12'h222;
        wdata[2]  = 32'hBBBB;
        tick();
        chk("t4_en", 32'(u_en), 32'd1);
        chk("t4_addr", 32'(u_addr), 32'h100);
        chk("t4_data", u_data, 32'hAAAA);
        en[0]    = 1'b0;
        wr_en[0] = 1'b0;
        tick();
        chk("t4_en_owner", 32'(u_en), 32'd0);
        chk("t4_wr_owner", 32'(u_wr), 32'd0);
        chk("t4_no_core2", 32'(u_addr), 32'h100);
        chk("t4_grant_keep", 32'(grant), 32'h1);
        locked[0] = 1'b0;
        req[0]    = 1'b0;
        tick();
        chk("t4_release", 32'(grant), 32'd0);
        repeat (3) begin
            tick();
            chk("t4_nonowner_lock", 32'(grant), 32'd0);
            chk("t4_port_idle", 32'(u_en), 32'd0);
            chk("t4_owner_keep", 32'(owner), 32'd0);
        end
        locked[2] = 1'b0;
        en[2]     = 1'b0;
        wr_en[2]  = 1'b0;

        // T5: core3 never locks while core0 waits; pointer is at 1 so core3 wins first
        req[3] = 1'b1;
        req[0] = 1'b1;
        tick();
        chk("t5_grant", 32'(grant), 32'h8);
        chk("t5_owner", 32'(owner), 32'd3);
`ifdef ARB_GRANT_TIMEOUT_EN
        repeat (7) begin
            tick();
            chk("t5_wait", 32'(grant), 32'h8);
            chk("t5_no_tmo", 32'(tmo), 32'd0);
        end
        tick();
        chk("t5_revoked", 32'(grant), 32'd0);
        chk("t5_tmo_pulse", 32'(tmo), 32'd1);
        tick();
        chk("t5_next", 32'(grant), 32'h1);
        chk("t5_tmo_once", 32'(tmo), 32'd0);
        req[3] = 1'b0;
`else
        repeat (100) begin
            tick();
            chk("t5_hold", 32'(grant), 32'h8);
            chk("t5_tmo_zero", 32'(tmo), 32'd0);
        end
        req[3] = 1'b0;
        tick();
        chk("t5_reqdrop", 32'(grant), 32'd0);
        tick();
        chk("t5_next", 32'(grant), 32'h1);
`endif
        req[0] = 1'b0;
        tick();
        chk("t5_release", 32'(grant), 32'd0);
        tick();

        // T6: reset in the middle of a core1 write
        req[1] = 1'b1;
        tick();
        chk("t6_grant", 32'(grant), 32'h2);
        locked[1] = 1'b1;
        en[1]     = 1'b1;
        wr_en[1]  = 1'b1;
        addr[1]   = 12'h0AB;
        wdata[1]  = 32'h77;
        tick();
        chk("t6_en", 32'(u_en), 32'd1);
        chk("t6_addr", 32'(u_addr), 32'h0AB);
        reset  = 1'b1;
        req[0] = 1'b1;
        tick();
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_en", 32'(u_en), 32'd0);
        chk("t6_rst_wr", 32'(u_wr), 32'd0);
        chk("t6_rst_addr", 32'(u_addr), 32'd0);
        chk("t6_rst_owner", 32'(owner), 32'd0);
        reset = 1'b0;
        tick();
        chk("t6_core0_wins", 32'(grant), 32'h1);
        chk("t6_owner", 32'(owner), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
